// File: rtl/dh_key_verify_pkg.sv
// Shared definitions for the Diffie-Hellman key verification stage.
//   DH_W        : default operand width
//   top_state_e : top-level sequencing states
//   eng_state_e : modular-exponentiation engine states
package dh_pkg;

    localparam int unsigned DH_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHK,
        ST_EXP_A,
        ST_EXP_B,
        ST_EXP_K1,
        ST_EXP_K2,
        ST_CMP,
        ST_REPORT1,
        ST_REPORT2
    } top_state_e;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_LOAD,
        ENG_SQR,
        ENG_MUL,
        ENG_DONE
    } eng_state_e;

endpackage

// File: rtl/dh_key_verify_if.sv
// Request/result bundle between the key-exchange controller and dh_key_verify.
//   start, p, g, a, b          : request and public/private operands (controller -> verifier)
//   busy, err, true_1, true_2  : status and qualifiers (verifier -> controller)
//   pub_a, pub_b, shared_key   : computed keys (verifier -> controller)
interface dh_key_verify_if
    import dh_pkg::*;
#(
    parameter int unsigned W = DH_W
) ();

    logic         start;
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         err;
    logic         true_1;
    logic         true_2;
    logic [W-1:0] pub_a;
    logic [W-1:0] pub_b;
    logic [W-1:0] shared_key;

    modport master (
        output start, p, g, a, b,
        input  busy, err, true_1, true_2, pub_a, pub_b, shared_key
    );

    modport slave (
        input  start, p, g, a, b,
        output busy, err, true_1, true_2, pub_a, pub_b, shared_key
    );

endinterface

// File: rtl/dh_key_verify_modexp.sv
// Modular exponentiation engine: result = base^exp mod mod.
// MSB-first square-and-multiply; each square/multiply is an interleaved
// shift-add modular multiply taking W+1 cycles (1 load + W iterations).
//   clk, rst        : clock, asynchronous active-low reset
//   start           : accepted in IDLE or DONE; captures base/exp/mod
//   base, exp, mod  : operands (base must be < mod)
//   busy            : engine not idle
//   done            : one-cycle pulse while result is valid
//   result          : last computed power
module dh_modexp
    import dh_pkg::*;
#(
    parameter int unsigned W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] base,
    input  logic [W-1:0] exp,
    input  logic [W-1:0] mod,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CW = $clog2(W + 1);

    eng_state_e   state, state_nx;
    logic [IW-1:0] bit_idx;
    logic [CW-1:0] cnt;
    logic [W-1:0]  base_q, exp_q, mod_q;
    logic [W-1:0]  res, r, y_sh;
    logic [W:0]    mod_x, dbl, dbl_red, add, sum, sum_red;
    logic [W-1:0]  r_nx;
    logic          op_last;
    logic          accept;

    assign accept  = start && ((state == ENG_IDLE) || (state == ENG_DONE));
    assign op_last = (cnt == CW'(W));

    // One shift-add step: r = 2r mod p, then optionally r = r + res mod p
    always_comb begin
        mod_x   = {1'b0, mod_q};
        dbl     = {r, 1'b0};
        dbl_red = (dbl >= mod_x) ? (dbl - mod_x) : dbl;
        add     = y_sh[W-1] ? {1'b0, res} : '0;
        sum     = dbl_red + add;
        sum_red = (sum >= mod_x) ? (sum - mod_x) : sum;
        r_nx    = sum_red[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ENG_IDLE;
        else      state <= state_nx;
    end

    // Next state: square every bit, multiply on set bits, LSB ends the run
    always_comb begin
        state_nx = state;
        case (state)
            ENG_IDLE: if (start) state_nx = ENG_LOAD;
            ENG_LOAD: state_nx = ENG_SQR;
            ENG_SQR: begin
                if (op_last) begin
                    if (exp_q[bit_idx])          state_nx = ENG_MUL;
                    else if (bit_idx == '0)      state_nx = ENG_DONE;
                end
            end
            ENG_MUL: begin
                if (op_last) state_nx = (bit_idx == '0) ? ENG_DONE : ENG_SQR;
            end
            ENG_DONE: state_nx = start ? ENG_LOAD : ENG_IDLE;
            default:  state_nx = ENG_IDLE;
        endcase
    end

    // Datapath and registered status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            res     <= '0;
            r       <= '0;
            y_sh    <= '0;
            bit_idx <= '0;
            cnt     <= '0;
        end else begin
            busy <= (state_nx != ENG_IDLE);
            done <= (state_nx == ENG_DONE);
            if (state_nx == ENG_DONE) result <= r_nx;
            if (accept) begin
                base_q <= base;
                exp_q  <= exp;
                mod_q  <= mod;
            end
            case (state)
                ENG_LOAD: begin
                    res     <= W'(1);
                    bit_idx <= IW'(W - 1);
                    cnt     <= '0;
                end
                ENG_SQR, ENG_MUL: begin
                    if (cnt == '0) begin
                        // Load cycle: multiplier is res for a square, base for a multiply
                        r    <= '0;
                        y_sh <= (state == ENG_SQR) ? res : base_q;
                        cnt  <= cnt + CW'(1);
                    end else begin
                        r    <= r_nx;
                        y_sh <= y_sh << 1;
                        if (op_last) begin
                            res <= r_nx;
                            cnt <= '0;
                            // A square on a set bit keeps the bit for the following multiply
                            if ((state == ENG_MUL) || !exp_q[bit_idx])
                                bit_idx <= bit_idx - IW'(1);
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dh_key_verify.sv
// Diffie-Hellman verification stage: checks (p, g), computes both public keys
// and both shared keys on one shared modexp engine, then reports
// true_1 (public keys valid) followed by true_2 (shared keys agree).
//   clk, rst : clock, asynchronous active-low reset
//   bus      : slave side of dh_key_verify_if (start/p/g/a/b in;
//              busy/err/true_1/true_2/pub_a/pub_b/shared_key out)
module dh_key_verify
    import dh_pkg::*;
#(
    parameter int unsigned W = DH_W
) (
    input  logic           clk,
    input  logic           rst,
    dh_key_verify_if.slave bus
);

    top_state_e   state, state_nx;
    logic [W-1:0] p_q, g_q, a_q, b_q;
    logic [W-1:0] pub_a_q, pub_b_q, key_q, k2_q;
    logic         busy_q, err_q, true_1_q, true_2_q, eq_q;
    logic         chk_ok, valid1, eq;
    logic         eng_start, eng_busy, eng_done;
    logic [W-1:0] eng_base, eng_exp, eng_result;

    assign chk_ok = p_q[0] && (p_q >= W'(3)) && (g_q >= W'(2)) && (g_q <= (p_q - W'(1)));
    assign valid1 = (pub_a_q > W'(1)) && (pub_b_q > W'(1));
    assign eq     = (key_q == k2_q);

    dh_modexp #(.W(W)) u_modexp (
        .clk    (clk),
        .rst    (rst),
        .start  (eng_start),
        .base   (eng_base),
        .exp    (eng_exp),
        .mod    (p_q),
        .busy   (eng_busy),
        .done   (eng_done),
        .result (eng_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;
    end

    // Sequencing; each engine start presents the operands of the next run
    always_comb begin
        state_nx  = state;
        eng_start = 1'b0;
        eng_base  = g_q;
        eng_exp   = a_q;
        case (state)
            ST_IDLE: if (bus.start) state_nx = ST_CHK;
            ST_CHK: begin
                if (chk_ok) begin
                    state_nx  = ST_EXP_A;
                    eng_start = 1'b1;
                end else begin
                    state_nx  = ST_IDLE;
                end
            end
            ST_EXP_A: begin
                eng_exp = b_q;
                if (eng_done) begin
                    state_nx  = ST_EXP_B;
                    eng_start = 1'b1;
                end
            end
            ST_EXP_B: begin
                // pub_b is being registered this cycle, so feed the engine result directly
                eng_base = eng_result;
                if (eng_done) begin
                    state_nx  = ST_EXP_K1;
                    eng_start = 1'b1;
                end
            end
            ST_EXP_K1: begin
                eng_base = pub_a_q;
                eng_exp  = b_q;
                if (eng_done) begin
                    state_nx  = ST_EXP_K2;
                    eng_start = 1'b1;
                end
            end
            ST_EXP_K2:  if (eng_done) state_nx = ST_CMP;
            ST_CMP:     if (!eng_busy) state_nx = ST_REPORT1;
            ST_REPORT1: state_nx = ST_REPORT2;
            ST_REPORT2: state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Operand capture, result registers and qualifiers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q      <= '0;
            g_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pub_a_q  <= '0;
            pub_b_q  <= '0;
            key_q    <= '0;
            k2_q     <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            true_1_q <= 1'b0;
            true_2_q <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            busy_q   <= state_nx inside {ST_CHK, ST_EXP_A, ST_EXP_B, ST_EXP_K1, ST_EXP_K2, ST_CMP};
            true_1_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        p_q      <= bus.p;
                        g_q      <= bus.g;
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        err_q    <= 1'b0;
                        true_2_q <= 1'b0;
                        pub_a_q  <= '0;
                        pub_b_q  <= '0;
                        key_q    <= '0;
                    end
                end
                ST_CHK:    if (!chk_ok) err_q <= 1'b1;
                ST_EXP_A:  if (eng_done) pub_a_q <= eng_result;
                ST_EXP_B:  if (eng_done) pub_b_q <= eng_result;
                ST_EXP_K1: if (eng_done) key_q <= eng_result;
                ST_EXP_K2: if (eng_done) k2_q <= eng_result;
                ST_CMP: begin
                    if (!eng_busy) begin
                        true_1_q <= valid1;
                        eq_q     <= eq;
                    end
                end
                // true_1 currently holds valid1
                ST_REPORT1: true_2_q <= true_1_q & eq_q;
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.err        = err_q;
    assign bus.true_1     = true_1_q;
    assign bus.true_2     = true_2_q;
    assign bus.pub_a      = pub_a_q;
    assign bus.pub_b      = pub_b_q;
    assign bus.shared_key = key_q;

endmodule

// File: tb/tb_dh_key_verify.sv
// Self-checking bench for dh_key_verify: directed vector table, randomized
// vectors against an arithmetic reference model, and reset/start corner cases.
module tb_dh_key_verify;

    localparam int unsigned W = 8;

    typedef struct {
        int p;
        int g;
        int a;
        int b;
        bit err;
        int pub_a;
        int pub_b;
        int key;
        bit t1;
        bit t2;
        int poke;       // cycle after accept at which a stray start is pulsed (0 = none)
        bit r2_start;   // pulse start during the REPORT2 cycle
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[13];

    dh_key_verify_if #(.W(W)) bus ();

    dh_key_verify #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Right-to-left binary exponentiation with plain integer arithmetic
    function automatic int mexp(input int base, input int e, input int m);
        int r  = 1 % m;
        int bb = base % m;
        int ee = e;
        while (ee > 0) begin
            if ((ee & 1) != 0) r = (r * bb) % m;
            bb = (bb * bb) % m;
            ee = ee >> 1;
        end
        return r;
    endfunction

    function automatic bit param_ok(input int p, input int g);
        return (p % 2 == 1) && (p >= 3) && (g >= 2) && (g <= p - 1);
    endfunction

    // Engine cycles for one exponentiation: load + (W+1) per square and per multiply + done
    function automatic int run_len(input int e);
        return 2 + (W + 1) * (W + $countones(e));
    endfunction

    function automatic vec_t build_vec(input int p, input int g, input int a, input int b);
        vec_t v;
        int   k2;
        v.p = p; v.g = g; v.a = a; v.b = b;
        v.poke = 0; v.r2_start = 1'b0;
        v.err = !param_ok(p, g);
        if (v.err) begin
            v.pub_a = 0; v.pub_b = 0; v.key = 0; v.t1 = 1'b0; v.t2 = 1'b0;
        end else begin
            v.pub_a = mexp(g, a, p);
            v.pub_b = mexp(g, b, p);
            v.key   = mexp(v.pub_b, a, p);
            k2      = mexp(v.pub_a, b, p);
            v.t1    = (v.pub_a > 1) && (v.pub_b > 1);
            v.t2    = v.t1 && (v.key == k2);
        end
        return v;
    endfunction

    // Returns at the negedge of the first cycle after acceptance (CHK)
    task automatic apply_start(input vec_t v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.p = 8'(v.p); bus.g = 8'(v.g); bus.a = 8'(v.a); bus.b = 8'(v.b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.p = 8'($urandom); bus.g = 8'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   n;
        int   rep;
        int   exp_rep;
        bit   early;
        logic err_r, t1_r, t2_r, t1_n, t2_n, t2_h, busy_h;
        exp_rep = v.err ? 2 : 3 + 2 * run_len(v.a) + 2 * run_len(v.b);
        apply_start(v);
        n = 1; rep = 0; early = 1'b0;
        while (rep == 0 && n < 4000) begin
            bus.start = (n == v.poke);
            if (!bus.busy) begin
                rep = n;
            end else begin
                if (bus.true_1 || bus.true_2 || bus.err) early = 1'b1;
                @(negedge clk);
                n++;
            end
        end
        bus.start = 1'b0;
        err_r = bus.err; t1_r = bus.true_1; t2_r = bus.true_2;
        @(negedge clk);
        t1_n = bus.true_1; t2_n = bus.true_2;
        if (v.r2_start) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        t2_h = bus.true_2; busy_h = bus.busy;
        chk({tag, "_latency"}, rep, exp_rep);
        chk({tag, "_early_flag"}, early, 0);
        chk({tag, "_err"}, err_r, v.err);
        chk({tag, "_true1_report1"}, t1_r, v.t1);
        chk({tag, "_true2_report1"}, t2_r, 0);
        chk({tag, "_true1_after"}, t1_n, 0);
        chk({tag, "_true2_report2"}, t2_n, v.t2);
        chk({tag, "_true2_held"}, t2_h, v.t2);
        chk({tag, "_busy_idle"}, busy_h, 0);
        chk({tag, "_pub_a"}, bus.pub_a, v.pub_a);
        chk({tag, "_pub_b"}, bus.pub_b, v.pub_b);
        chk({tag, "_shared_key"}, bus.shared_key, v.key);
    endtask

    initial begin
        vec_t v;
        int   p, g;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.p = '0; bus.g = '0; bus.a = '0; bus.b = '0;

        //            p    g    a    b   err  pa   pb   key  t1   t2  poke r2
        vecs[0]  = '{23,   5,   6,  15, 1'b0,  8,  19,   2, 1'b1, 1'b1, 0, 1'b0};
        vecs[1]  = '{22,   5,   6,  15, 1'b1,  0,   0,   0, 1'b0, 1'b0, 0, 1'b0};
        vecs[2]  = '{23,   5,   0,   7, 1'b0,  1,  17,   1, 1'b0, 1'b0, 0, 1'b0};
        vecs[3]  = '{23,   5,   5,   1, 1'b0, 20,   5,  20, 1'b1, 1'b1, 0, 1'b0};
        vecs[4]  = '{23,   5,   6,  15, 1'b0,  8,  19,   2, 1'b1, 1'b1, 99, 1'b0};
        vecs[5]  = '{ 3,   2,   3,   2, 1'b0,  2,   1,   1, 1'b0, 1'b0, 0, 1'b0};
        vecs[6]  = '{23,  23,   3,   4, 1'b1,  0,   0,   0, 1'b0, 1'b0, 0, 1'b0};
        vecs[7]  = '{23,   1,   3,   4, 1'b1,  0,   0,   0, 1'b0, 1'b0, 0, 1'b0};
        vecs[8]  = '{ 1,   0,   3,   4, 1'b1,  0,   0,   0, 1'b0, 1'b0, 0, 1'b0};
        vecs[9]  = '{23,  22,   3,   4, 1'b0, 22,   1,   1, 1'b0, 1'b0, 0, 1'b0};
        vecs[10] = '{255, 254, 255, 255, 1'b0, 254, 254, 254, 1'b1, 1'b1, 0, 1'b0};
        vecs[11] = '{ 9,   3,   2,   1, 1'b0,  0,   3,   0, 1'b0, 1'b0, 0, 1'b0};
        vecs[12] = '{23,   5,   6,  15, 1'b0,  8,  19,   2, 1'b1, 1'b1, 0, 1'b1};

        #12;
        chk("reset_outputs", {bus.busy, bus.err, bus.true_1, bus.true_2,
                              bus.pub_a, bus.pub_b, bus.shared_key}, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during EXP_K1, then a fresh run
        apply_start(vecs[0]);
        repeat (run_len(6) + run_len(15) + 11) @(negedge clk);
        chk("pre_reset_pub_b", bus.pub_b, 19);
        rst = 1'b0;
        #1;
        chk("midop_reset_outputs", {bus.busy, bus.err, bus.true_1, bus.true_2,
                                    bus.pub_a, bus.pub_b, bus.shared_key}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("midop_reset_hold", {bus.busy, bus.err, bus.true_1, bus.true_2,
                                 bus.pub_a, bus.pub_b, bus.shared_key}, 0);
        rst = 1'b1;
        run_vec(vecs[0], "post_reset");

        // Randomized vectors against the reference model
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                p = 2 * int'($urandom_range(1, 127)) + 1;
                g = int'($urandom_range(2, p - 1));
            end else begin
                p = int'($urandom_range(0, 255));
                g = int'($urandom_range(0, 255));
            end
            v = build_vec(p, g, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            if (!v.err && $urandom_range(0, 3) == 0) v.poke = int'($urandom_range(2, 40));
            run_vec(v, $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dh_key_verify.md
# dh_key_verify

Upstream verification stage of the Diffie-Hellman exchange. It takes the public parameters (p, g) and both private exponents (a, b) and computes both public keys and both shared keys with one shared modular-exponentiation engine. It then drives the controller's `true_1`/`true_2` qualifiers: public keys valid, and shared keys equal.

## Interface
- `W`, default 8: operand width in bits for p, g, a, b and all results.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low; clock `clk`.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `p`  in  W  modulus; captured on accepted `start`.
- `g`  in  W  generator; captured on accepted `start`.
- `a`  in  W  first private exponent; captured on accepted `start`.
- `b`  in  W  second private exponent; captured on accepted `start`.
- `busy`  out  1  high from the cycle after accept until REPORT1.
- `err`  out  1  parameter check failed; held until next accepted `start`.
- `true_1`  out  1  one-cycle pulse: both public keys valid.
- `true_2`  out  1  level: shared keys equal; held until next accepted `start`.
- `pub_a`  out  W  g^a mod p, registered.
- `pub_b`  out  W  g^b mod p, registered.
- `shared_key`  out  W  K1 = pub_b^a mod p, registered.

## Operation
- **Reset values:** every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately; no partial result remains visible.
- **Top FSM states:** IDLE, CHK, EXP_A, EXP_B, EXP_K1, EXP_K2, CMP, REPORT1, REPORT2.
- **IDLE:**
  - On `start`, capture p/g/a/b, clear `err`, `true_2`, `pub_a`, `pub_b`, `shared_key`, then go to CHK.
  - `start` is ignored in every other state.
- **CHK (1 cycle):**
  - p must be odd and ≥ 3, and g must satisfy 2 ≤ g ≤ p−1.
  - On failure, set `err` and return to IDLE. `true_1`/`true_2` are never asserted.
- **EXP_A / EXP_B / EXP_K1 / EXP_K2:** sequential runs of the engine computing g^a, g^b, pub_b^a, and pub_a^b (the last is K2, internal only). Each result is registered when the engine finishes.
- **CMP (1 cycle):**
  - valid1 = pub_a ∉ {0, 1} and pub_b ∉ {0, 1}.
  - eq = (K1 == K2).
- **REPORT1 (1 cycle):** `true_1` = valid1, then go to REPORT2.
- **REPORT2:**
  - `true_2` = valid1 & eq, held.
  - Return to IDLE in the same cycle. `true_2` stays asserted while idle.
  - A new `start` clears it.
- **Engine (modexp):**
  - MSB-first square-and-multiply: res = 1; for bit i = W−1 down to 0: res = res·res mod p; if e[i], res = res·base mod p.
  - Exponent 0 yields 1.
- **Modular multiply:**
  - Interleaved shift-add, MSB-first over the multiplier: r = 0; per bit: r = 2r mod p, then if y[i], r = r + x mod p.
  - Intermediates are W+1 bits. Each reduction is a single conditional subtract of p; no values ≥ 2p occur because inputs are < p.

## Timing
- **Modmul:** exactly W+1 cycles (1 load + W iterations).
- **Modexp with exponent e:**
  - Cycle count: 1 + Σ_i (W+1)·(1 + e[i]) + 1.
  - The final `+1` is the done cycle, in which the result is registered.
  - Example, W=8, e=0x05: 1 + 8·9 + 2·9 + 1 = 92 cycles.
- **Total:** accept → REPORT1 = 1 (CHK) + four modexp runs + 1 (CMP).
- **Output ordering:**
  - `true_1` is high for exactly the one cycle in REPORT1.
  - `true_2` rises on the next cycle, so the downstream controller sees true_1 followed immediately by true_2.
- `busy` falls on the REPORT1 cycle.
- **Simultaneous events:** `start` in the same cycle as REPORT2 → IDLE is not accepted. It is accepted from IDLE on the following cycle.

## Structure
- **Shared package `dh_pkg`:**
  - Top FSM state encoding.
  - Engine state encoding (IDLE, LOAD, SQR, MUL, DONE).
  - Width parameter default `DH_W = 8`.
- **Sub-module `dh_modexp`:** square-and-multiply with an embedded shift-add multiplier.
  - Inputs: start, base, exp, mod.
  - Outputs: busy, done, result.
  - `done` is a one-cycle pulse.
- The top instantiates a single `dh_modexp` and muxes base/exp per state.

## Test plan
- p=23, g=5, a=6, b=15 → pub_a=8, pub_b=19, shared_key=2. `true_1` pulse, then `true_2`=1 on the next cycle and held. `err`=0.
- p=22, g=5 → `err`=1 two cycles after `start`; `true_1`/`true_2` never assert; back in IDLE.
- p=23, g=5, a=0, b=7 → pub_a=1, valid1=0. `true_1` stays 0 in REPORT1 and `true_2`=0. Operation completes normally.
- Latency check, p=23, g=5, a=5, b=1, W=8:
  - Each modexp cycle count matches the formula: 92 cycles for e=5, 83 cycles for e=1.
  - `busy` low exactly on REPORT1.
- `start` pulsed mid-EXP_B → ignored; results are identical to the undisturbed run.
- Reset asserted during EXP_K1, then released and a fresh start with p=23, g=5, a=6, b=15 → all outputs are 0 during reset; the full correct result appears after the fresh run.
